// File: rtl/alu_pipe.sv
// alu_pipe: pipelined signed ALU with credit-gated result FIFO; define ALU_SAT_EN to saturate ADD/SUB
module alu_pipe #(
    parameter int W     = 5,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ALU_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] A,
    input  logic signed [W-1:0] B,
    input  logic                a_en,
    input  logic [2:0]          a_op,
    input  logic                b_en,
    input  logic [1:0]          b_op,
    input  logic                C_ready,
    output logic                C_en,
    output logic signed [W:0]   C,
    output logic                err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + LAT + 1);

    logic signed [W:0] w_sa, w_sb, w_res;
    logic [W-1:0]      w_x, w_n, w_o;
    logic              w_err, w_acc, w_push, w_pop;
    logic [CW-1:0]     w_infl;
    logic [W+1:0]      w_head;

    logic [LAT-1:0]    r_pv;
    logic [W:0]        r_pd [LAT];
    logic              r_pe [LAT];
    logic [W+1:0]      r_mem [DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_cnt;

    always_comb begin
        w_sa  = {A[W-1], A};
        w_sb  = {B[W-1], B};
        w_x   = A ^ B;
        w_n   = A & B;
        w_o   = A | B;
        w_res = '0;
        w_err = 1'b0;
        if (a_en && b_en) w_err = 1'b1;
        else if (a_en) begin
            case (a_op)
                3'd0:    w_res = w_sa + w_sb;
                3'd1:    w_res = w_sa - w_sb;
                3'd2:    w_res = {w_x[W-1], w_x};
                3'd3:    w_res = {w_n[W-1], w_n};
                3'd4:    w_res = {w_o[W-1], w_o};
                3'd5:    w_res = {~w_x[W-1], ~w_x};
                3'd6:    w_res = {~w_n[W-1], ~w_n};
                default: w_err = 1'b1;
            endcase
`ifdef ALU_SAT_EN
            if (a_op < 3'd2 && w_res[W] != w_res[W-1]) begin
                w_res = w_res[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
                w_err = 1'b1;
            end
`endif
        end else if (b_en) begin
            case (b_op)
                2'd0:    w_res = (W+1)'(A == B);
                2'd1:    w_res = (W+1)'(A > B);
                2'd2:    w_res = (W+1)'(A < B);
                default: w_res = (A > B) ? w_sa : w_sb;
            endcase
        end
    end

    always_comb begin
        w_infl = '0;
        for (int i = 0; i < LAT; i++) w_infl = w_infl + CW'(r_pv[i]);
    end

    assign in_ready = ALU_en && !rst_n && (r_cnt + w_infl < CW'(DEPTH));
    assign w_acc    = in_valid && in_ready;
    assign w_push   = ALU_en && r_pv[LAT-1];
    assign w_pop    = C_en && C_ready;
    assign w_head   = r_mem[r_rp];
    assign C_en     = ALU_en && (r_cnt != '0);
    assign C        = C_en ? w_head[W:0] : '0;
    assign err      = C_en && w_head[W+1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pv  <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (ALU_en) begin
            r_pv[0] <= w_acc;
            for (int i = 1; i < LAT; i++) r_pv[i] <= r_pv[i-1];
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (ALU_en) begin
            r_pd[0] <= w_res;
            r_pe[0] <= w_err;
            for (int i = 1; i < LAT; i++) begin
                r_pd[i] <= r_pd[i-1];
                r_pe[i] <= r_pe[i-1];
            end
            if (w_push) r_mem[r_wp] <= {r_pe[LAT-1], r_pd[LAT-1]};
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus backpressure, enable-gap and reset sequences for alu_pipe
module tb_alu_pipe;
    localparam int W = 5, LAT = 2, DEPTH = 4, NV = 16;

    logic clk = 1'b0, rst_n, ALU_en = 1'b1, in_valid = 1'b0, a_en = 1'b0, b_en = 1'b0, C_ready = 1'b1;
    logic [2:0] a_op = '0;
    logic [1:0] b_op = '0;
    logic signed [W-1:0] A = '0, B = '0;
    logic in_ready, C_en, err;
    logic signed [W:0] C;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic ae; logic [2:0] ao; logic be; logic [1:0] bo;
        int a; int b; int c; logic e;
    } vec_t;
    vec_t v [NV];

    always #5 clk = ~clk;

    alu_pipe #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ALU_en(ALU_en), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .a_en(a_en), .a_op(a_op), .b_en(b_en), .b_op(b_op),
        .C_ready(C_ready), .C_en(C_en), .C(C), .err(err)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic set_add(input int a);
        a_en = 1'b1; a_op = 3'd0; b_en = 1'b0; b_op = 2'd0;
        A = W'(a); B = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, n, got, sent, stale;
`ifdef ALU_SAT_EN
        v[0]  = '{1, 0, 0, 0,  15,  15,  15, 1};
        v[1]  = '{1, 1, 0, 0, -16,  15, -16, 1};
        v[14] = '{1, 0, 0, 0, -16, -16, -16, 1};
        v[15] = '{1, 1, 0, 0,   7,  -9,  15, 1};
`else
        v[0]  = '{1, 0, 0, 0,  15,  15,  30, 0};
        v[1]  = '{1, 1, 0, 0, -16,  15, -31, 0};
        v[14] = '{1, 0, 0, 0, -16, -16, -32, 0};
        v[15] = '{1, 1, 0, 0,   7,  -9,  16, 0};
`endif
        v[2]  = '{1, 2, 0, 0,   5,   3,   6, 0};
        v[3]  = '{1, 3, 0, 0,  -3,   6,   4, 0};
        v[4]  = '{1, 4, 0, 0,   9, -16,  -7, 0};
        v[5]  = '{1, 5, 0, 0,   5,   3,  -7, 0};
        v[6]  = '{1, 6, 0, 0,   5,   3,  -2, 0};
        v[7]  = '{1, 7, 0, 0,   5,   3,   0, 1};
        v[8]  = '{0, 0, 1, 0,   4,   4,   1, 0};
        v[9]  = '{0, 0, 1, 1,  -1,  -2,   1, 0};
        v[10] = '{0, 0, 1, 2,  -1,  -2,   0, 0};
        v[11] = '{0, 0, 1, 3,  -3,   2,   2, 0};
        v[12] = '{1, 0, 1, 3,   5,   3,   0, 1};
        v[13] = '{0, 0, 0, 0,   5,   3,   0, 0};

        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #2;
        chk("reset in_ready", in_ready, 0);
        chk("reset C_en", C_en, 0);
        chk("reset C", C, 0);
        chk("reset err", err, 0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_en = v[i].ae; a_op = v[i].ao; b_en = v[i].be; b_op = v[i].bo;
            A = W'(v[i].a); B = W'(v[i].b);
            in_valid = 1'b1;
            #1 chk($sformatf("v%0d in_ready", i), in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            #1 k = 1;
            while (!C_en && k < 20) begin
                @(negedge clk);
                #1 k++;
            end
            chk($sformatf("v%0d latency", i), k, LAT + 1);
            chk($sformatf("v%0d C", i), C, v[i].c);
            chk($sformatf("v%0d err", i), err, v[i].e);
        end

        @(negedge clk);
        C_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            set_add(n + 1);
            in_valid = 1'b1;
            #1 if (in_ready) n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("bp accepts", n, DEPTH);
        chk("bp in_ready", in_ready, 0);
        chk("bp C_en", C_en, 1);
        chk("bp head held", C, 1);
        C_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (C_en) begin
                chk($sformatf("bp order %0d", got), C, got + 1);
                got++;
            end
            @(negedge clk);
            #1;
        end
        chk("bp drained", got, DEPTH);
        chk("bp in_ready back", in_ready, 1);

        sent = 0;
        got = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ALU_en = !(c >= 3 && c <= 5);
            set_add(10 + sent);
            in_valid = (sent < 6);
            #1;
            if (!ALU_en) begin
                chk($sformatf("gap%0d C_en", c), C_en, 0);
                chk($sformatf("gap%0d C", c), C, 0);
                chk($sformatf("gap%0d in_ready", c), in_ready, 0);
            end
            if (in_valid && in_ready) sent++;
            if (C_en) begin
                chk($sformatf("gap order %0d", got), C, 10 + got);
                got++;
            end
        end
        in_valid = 1'b0;
        chk("gap sent", sent, 6);
        chk("gap received", got, 6);

        @(negedge clk);
        C_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            set_add(c + 1);
            in_valid = 1'b1;
            #1 if (in_ready) n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("pre-rst accepts", n, 4);
        chk("pre-rst C_en", C_en, 1);
        rst_n = 1'b1;
        #1;
        chk("rst C_en", C_en, 0);
        chk("rst C", C, 0);
        chk("rst in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        C_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            #1 if (C_en) stale++;
            @(negedge clk);
        end
        chk("post-rst stale", stale, 0);
        a_en = 1'b1; a_op = 3'd0; b_en = 1'b0; A = 5'sd3; B = 5'sd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 k = 1;
        while (!C_en && k < 20) begin
            @(negedge clk);
            #1 k++;
        end
        chk("post-rst latency", k, LAT + 1);
        chk("post-rst C", C, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
